bottle_scheduler: RTL and testbench
===================================

# bottle_scheduler

Game-level controller for the pilsner falling-bottle game. It owns N bottle lanes and decides when each lane launches, using a pseudo-random lane choice and a spawn interval that shortens with level. It retires bottles on catch or miss, and keeps score, level and miss count. It sits between the player/collision logic and the per-lane bottle objects: it drives each bottle's launch and retire inputs and consumes each bottle's active, caught and missed status.

## Interface
Parameters:
- N_LANES, 4, number of bottle lanes (2..8)
- SPAWN_DELAY, 25_000_000, spawn interval in cycles at level 0
- SPAWN_STEP, 2_000_000, interval reduction per level
- SPAWN_MIN, 5_000_000, floor on spawn interval
- LEVEL_STEP, 10, catches per level increment
- MAX_LEVEL, 9, level saturation value
- MISS_LIMIT, 3, misses that end the game
- LFSR_SEED, 16'hACE1, non-zero LFSR reset value

Ports:
- clk  in  1  clock, 50 MHz
- reset  in  1  synchronous, active-low
- start  in  1  level-sensitive; starts a game from IDLE or GAME_OVER
- pause  in  1  freezes timer, LFSR and all counters while high
- lane_active  in  N_LANES  bottle currently falling
- lane_caught  in  N_LANES  1-cycle pulse: bottle collided with player while printed
- lane_missed  in  N_LANES  1-cycle pulse: bottle reached Y_MAX
- launch  out  N_LANES  one-hot 1-cycle pulse: start bottle in lane
- retire  out  N_LANES  1-cycle pulse: reset bottle in lane
- score  out  16  catches, saturating
- level  out  4  current level
- misses  out  2  miss count
- running  out  1  state == RUN
- game_over  out  1  state == GAME_OVER

## Operation
States:
- IDLE: entered on reset. `start` -> RUN, with score, level, misses and the catch-in-level counter all cleared and the timer loaded.
- RUN: `misses` reaches MISS_LIMIT -> GAME_OVER.
- GAME_OVER: `start` -> RUN, with the same clears as IDLE -> RUN.

Spawn timer:
- 32-bit down-counter, loaded with period = max(SPAWN_DELAY − level·SPAWN_STEP, SPAWN_MIN).
- Decrements in RUN when `pause` is low. At 0 it is "armed" and holds 0.

Launch selection:
- When armed, the lane start index is s = lfsr[2:0] mod N_LANES.
- Scan s, s+1, … (wrapping) for the first lane with lane_active=0 that is not launched or retired this cycle.
- If a lane is found: pulse `launch` on it, reload the timer, advance the LFSR one step.
- If no idle lane exists: stay armed and retry every cycle.

Events in RUN, evaluated per lane each cycle:
- caught → `retire` the lane, score += 1, catch-in-level += 1.
- missed → `retire` the lane, misses += 1.
- caught and missed on the same lane in the same cycle: caught wins, no miss.
- Multiple lanes in one cycle: score increases by the popcount of caught lanes; misses increase by the popcount of missed lanes, saturating at MISS_LIMIT.

Level:
- When catch-in-level ≥ LEVEL_STEP: level += 1 (saturating at MAX_LEVEL) and catch-in-level −= LEVEL_STEP.
- The new period applies at the next timer reload only.

Game end and idle behaviour:
- Entering GAME_OVER pulses `retire` on all lanes for exactly one cycle.
- Event inputs are ignored in IDLE and GAME_OVER.
- `pause` high: no launch, no counter updates, event pulses ignored. Bottles also pause, so no events are expected.

LFSR:
- 16-bit Fibonacci, taps 16, 14, 13, 11.
- Steps only on a launch, so the sequence is deterministic for the bench.

## Timing
- All outputs registered.
- Reset values (reset=0 at a clk edge): launch=0, retire=0, score=0, level=0, misses=0, running=0, game_over=0, state IDLE, lfsr=LFSR_SEED, timer=period(0).
- `start` sampled high → running=1 on the next edge.
- First launch fires period(level)+1 cycles after running rises.
- Timer expiry to launch pulse: 1 cycle.
- Event input pulse to `retire` and to the counter update: 1 cycle.
- Miss count reaching MISS_LIMIT: game_over and the all-lane `retire` pulse on the same edge.
- `reset` mid-game: all state returns to reset values on that edge; no retire pulse.

## Structure
- Add to constants.vh:
  - state encoding IDLE=2'd0, RUN=2'd1, GAME_OVER=2'd2
  - LFSR tap mask
  - MAX_LANES=8
- Sub-module `lfsr16`: clk, reset, enable, seed, q.
- Lane scan and popcount are combinational functions inside bottle_scheduler.

## Test plan
- Reset, then start=1 for one cycle, with SPAWN_DELAY=20, N_LANES=4: running=1 after 1 cycle; exactly one `launch` bit pulses at cycle 21; the lane index equals the seed-derived s.
- All 4 lane_active=1 when the timer expires: no launch while armed. Drop lane 2 active low at cycle +5 → launch=4'b0100 on the next cycle, then the timer reloads.
- Same cycle lane_caught=4'b0011, lane_missed=4'b0110: retire=4'b0111 one cycle later, score+=2, misses+=1.
- LEVEL_STEP=2, with 2 catches then 2 more: level 0→1→2. The next reload uses SPAWN_DELAY−2·SPAWN_STEP, clamped at SPAWN_MIN when level·SPAWN_STEP exceeds the margin.
- 3 misses: game_over=1, retire=4'b1111 for exactly one cycle, further events ignored. Then start → score, level and misses all 0 and running=1.
- pause=1 for 100 cycles mid-interval: the timer value and LFSR are unchanged and the launch is delayed by exactly 100 cycles. Reset asserted mid-RUN returns all outputs to their reset values.

Source files
------------

// File: rtl/bottle_scheduler_pkg.sv
// Shared encodings for the falling-bottle game controller and its LFSR.
package bottle_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RUN       = 2'd1,
        ST_GAME_OVER = 2'd2
    } state_e;

    // Fibonacci feedback taps 16, 14, 13, 11 expressed as bits 15, 13, 12, 10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam int MAX_LANES = 8;

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR that advances one step per cycle while enable is high.
module lfsr16
    import bottle_scheduler_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    logic [15:0] q_q;
    logic [15:0] q_d;

    always_comb begin
        q_d = q_q;
        if (enable) begin
            q_d = {q_q[14:0], ^(q_q & LFSR_TAPS)};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            q_q <= seed;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/bottle_scheduler.sv
// Game-level controller: launches bottles on a level-dependent spawn timer,
// retires them on catch or miss, and tracks score, level and misses.
module bottle_scheduler
    import bottle_scheduler_pkg::*;
#(
    parameter int          N_LANES     = 4,
    parameter int          SPAWN_DELAY = 25_000_000,
    parameter int          SPAWN_STEP  = 2_000_000,
    parameter int          SPAWN_MIN   = 5_000_000,
    parameter int          LEVEL_STEP  = 10,
    parameter int          MAX_LEVEL   = 9,
    parameter int          MISS_LIMIT  = 3,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               pause,
    input  logic [N_LANES-1:0] lane_active,
    input  logic [N_LANES-1:0] lane_caught,
    input  logic [N_LANES-1:0] lane_missed,
    output logic [N_LANES-1:0] launch,
    output logic [N_LANES-1:0] retire,
    output logic [15:0]        score,
    output logic [3:0]         level,
    output logic [1:0]         misses,
    output logic               running,
    output logic               game_over
);

    localparam logic [N_LANES-1:0] ONE_LANE   = {{(N_LANES-1){1'b0}}, 1'b1};
    localparam logic [15:0]        LVL_STEP16 = 16'(LEVEL_STEP);
    localparam logic [3:0]         MAX_LVL4   = 4'(MAX_LEVEL);
    localparam logic [4:0]         MISS_LIM5  = 5'(MISS_LIMIT);
    localparam logic [1:0]         MISS_LIM2  = 2'(MISS_LIMIT);

    function automatic logic [31:0] period_of(input logic [3:0] lvl);
        logic [63:0] dec;
        dec = 64'(lvl) * 64'(SPAWN_STEP);
        if (64'(SPAWN_DELAY) > dec + 64'(SPAWN_MIN)) begin
            return 32'(64'(SPAWN_DELAY) - dec);
        end
        return 32'(SPAWN_MIN);
    endfunction

    function automatic logic [3:0] popcount(input logic [N_LANES-1:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < N_LANES; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    // Walks downward so the lowest offset from the start lane wins.
    function automatic logic [N_LANES-1:0] scan_lanes(input logic [2:0] s,
                                                      input logic [N_LANES-1:0] busy);
        logic [N_LANES-1:0] pick;
        logic [N_LANES-1:0] busy_rot;
        int                 idx;
        pick = '0;
        for (int k = MAX_LANES - 1; k >= 0; k--) begin
            if (k < N_LANES) begin
                idx      = (int'(s) + k) % N_LANES;
                busy_rot = busy >> idx;
                if (!busy_rot[0]) begin
                    pick = ONE_LANE << idx;
                end
            end
        end
        return pick;
    endfunction

    state_e             state_q, state_d;
    logic [31:0]        timer_q, timer_d;
    logic [15:0]        score_q, score_d;
    logic [15:0]        cil_q, cil_d;
    logic [3:0]         level_q, level_d;
    logic [1:0]         misses_q, misses_d;
    logic [N_LANES-1:0] launch_q, launch_d;
    logic [N_LANES-1:0] retire_q, retire_d;
    logic               running_q, game_over_q;

    logic               lfsr_en;
    logic [15:0]        lfsr_q;
    logic               lfsr_unused;

    logic [N_LANES-1:0] caught_v, missed_v, busy, pick;
    logic [16:0]        score_sum;
    logic [15:0]        cil_sum;
    logic [4:0]         miss_sum;

    lfsr16 u_lfsr (
        .clk    (clk),
        .reset  (reset),
        .enable (lfsr_en),
        .seed   (LFSR_SEED),
        .q      (lfsr_q)
    );

    assign lfsr_unused = ^lfsr_q[15:3];

    always_comb begin
        caught_v  = lane_caught;
        missed_v  = lane_missed & ~lane_caught;
        score_sum = {1'b0, score_q} + 17'(popcount(caught_v));
        cil_sum   = cil_q + 16'(popcount(caught_v));
        miss_sum  = {3'b000, misses_q} + {1'b0, popcount(missed_v)};
        busy      = lane_active | launch_q | retire_q | caught_v | missed_v;
        pick      = scan_lanes(lfsr_q[2:0], busy);

        state_d  = state_q;
        timer_d  = timer_q;
        score_d  = score_q;
        cil_d    = cil_q;
        level_d  = level_q;
        misses_d = misses_q;
        launch_d = '0;
        retire_d = '0;
        lfsr_en  = 1'b0;

        case (state_q)
            ST_IDLE, ST_GAME_OVER: begin
                if (start) begin
                    state_d  = ST_RUN;
                    timer_d  = period_of(4'd0);
                    score_d  = '0;
                    cil_d    = '0;
                    level_d  = '0;
                    misses_d = '0;
                end
            end
            ST_RUN: begin
                if (!pause) begin
                    retire_d = caught_v | missed_v;
                    score_d  = score_sum[16] ? 16'hFFFF : score_sum[15:0];
                    if (cil_sum >= LVL_STEP16) begin
                        cil_d = cil_sum - LVL_STEP16;
                        if (level_q < MAX_LVL4) begin
                            level_d = level_q + 4'd1;
                        end
                    end else begin
                        cil_d = cil_sum;
                    end
                    misses_d = (miss_sum >= MISS_LIM5) ? MISS_LIM2 : miss_sum[1:0];

                    if (miss_sum >= MISS_LIM5) begin
                        state_d  = ST_GAME_OVER;
                        retire_d = '1;
                    end else if (timer_q == 32'd0) begin
                        // Armed: hold at zero and retry every cycle until a lane is free
                        if (pick != '0) begin
                            launch_d = pick;
                            timer_d  = period_of(level_q);
                            lfsr_en  = 1'b1;
                        end
                    end else begin
                        timer_d = timer_q - 32'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            timer_q     <= period_of(4'd0);
            score_q     <= '0;
            cil_q       <= '0;
            level_q     <= '0;
            misses_q    <= '0;
            launch_q    <= '0;
            retire_q    <= '0;
            running_q   <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            score_q     <= score_d;
            cil_q       <= cil_d;
            level_q     <= level_d;
            misses_q    <= misses_d;
            launch_q    <= launch_d;
            retire_q    <= retire_d;
            running_q   <= (state_d == ST_RUN);
            game_over_q <= (state_d == ST_GAME_OVER);
        end
    end

    assign launch    = launch_q;
    assign retire    = retire_q;
    assign score     = score_q;
    assign level     = level_q;
    assign misses    = misses_q;
    assign running   = running_q;
    assign game_over = game_over_q;

endmodule

// File: tb/tb_bottle_scheduler.sv
// Directed bench for bottle_scheduler with a short spawn interval and small level step.
module tb_bottle_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        pause;
    logic [3:0]  lane_active;
    logic [3:0]  lane_caught;
    logic [3:0]  lane_missed;
    logic [3:0]  launch;
    logic [3:0]  retire;
    logic [15:0] score;
    logic [3:0]  level;
    logic [1:0]  misses;
    logic        running;
    logic        game_over;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    bottle_scheduler #(
        .N_LANES     (4),
        .SPAWN_DELAY (20),
        .SPAWN_STEP  (4),
        .SPAWN_MIN   (8),
        .LEVEL_STEP  (2),
        .MAX_LEVEL   (9),
        .MISS_LIMIT  (3),
        .LFSR_SEED   (16'hACE1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .pause       (pause),
        .lane_active (lane_active),
        .lane_caught (lane_caught),
        .lane_missed (lane_missed),
        .launch      (launch),
        .retire      (retire),
        .score       (score),
        .level       (level),
        .misses      (misses),
        .running     (running),
        .game_over   (game_over)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic do_reset();
        reset       = 1'b0;
        start       = 1'b0;
        pause       = 1'b0;
        lane_active = 4'b0000;
        lane_caught = 4'b0000;
        lane_missed = 4'b0000;
        step(2);
        reset = 1'b1;
    endtask

    task automatic start_game(output int t0);
        start = 1'b1;
        step(1);
        start = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_launch(input int limit, output int at, output logic [3:0] val);
        at  = -1;
        val = 4'b0000;
        for (int i = 0; i < limit; i++) begin
            step(1);
            if (launch !== 4'b0000) begin
                at  = cyc;
                val = launch;
                break;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        reset = 1'b0;
        checks++;
        if ({launch, retire, score, level, misses, running, game_over} !== 34'd0) begin
            errors++;
            $display("FAIL reset_outputs: got launch=%b retire=%b score=%0d level=%0d misses=%0d running=%b game_over=%b, expected all zero",
                     launch, retire, score, level, misses, running, game_over);
        end
        reset = 1'b1;
        step(3);
        checks++;
        if (running !== 1'b0) begin
            errors++;
            $display("FAIL idle_without_start: running=%b expected 0", running);
        end
    endtask

    task automatic test_first_launch();
        int t0, at;
        logic [3:0] val;
        do_reset();
        start_game(t0);
        checks++;
        if (running !== 1'b1) begin
            errors++;
            $display("FAIL start_running: running=%b expected 1", running);
        end
        wait_launch(40, at, val);
        checks++;
        if (at - t0 !== 21) begin
            errors++;
            $display("FAIL first_launch_latency: got %0d cycles expected 21", at - t0);
        end
        checks++;
        if (val !== 4'b0010) begin
            errors++;
            $display("FAIL first_launch_lane: got %b expected 0010", val);
        end
        step(1);
        checks++;
        if (launch !== 4'b0000) begin
            errors++;
            $display("FAIL launch_single_pulse: got %b expected 0000", launch);
        end
    endtask

    task automatic test_all_busy();
        int t0, at, bad, prev;
        logic [3:0] val;
        do_reset();
        lane_active = 4'b1111;
        start_game(t0);
        bad = 0;
        for (int i = 0; i < 25; i++) begin
            step(1);
            if (launch !== 4'b0000) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL busy_no_launch: got %0d launch cycles expected 0", bad);
        end
        lane_active = 4'b1011;
        step(1);
        prev = cyc;
        checks++;
        if (launch !== 4'b0100) begin
            errors++;
            $display("FAIL busy_retry_launch: got %b expected 0100", launch);
        end
        lane_active = 4'b0111;
        wait_launch(40, at, val);
        checks++;
        if (at - prev !== 21) begin
            errors++;
            $display("FAIL busy_reload_interval: got %0d cycles expected 21", at - prev);
        end
        checks++;
        if (val !== 4'b1000) begin
            errors++;
            $display("FAIL busy_second_lane: got %b expected 1000", val);
        end
    endtask

    task automatic test_events();
        int t0;
        do_reset();
        start_game(t0);
        lane_caught = 4'b0011;
        lane_missed = 4'b0110;
        step(1);
        lane_caught = 4'b0000;
        lane_missed = 4'b0000;
        checks++;
        if (retire !== 4'b0111) begin
            errors++;
            $display("FAIL events_retire: got %b expected 0111", retire);
        end
        checks++;
        if (score !== 16'd2 || misses !== 2'd1) begin
            errors++;
            $display("FAIL events_counts: got score=%0d misses=%0d expected score=2 misses=1", score, misses);
        end
        checks++;
        if (level !== 4'd1) begin
            errors++;
            $display("FAIL events_level: got %0d expected 1", level);
        end
        step(1);
        checks++;
        if (retire !== 4'b0000) begin
            errors++;
            $display("FAIL events_retire_pulse: got %b expected 0000", retire);
        end
    endtask

    task automatic test_level();
        int t0, at1, at2, at3;
        logic [3:0] val;
        do_reset();
        start_game(t0);
        lane_caught = 4'b0001;
        step(1);
        checks++;
        if (level !== 4'd0) begin
            errors++;
            $display("FAIL level_after_one: got %0d expected 0", level);
        end
        step(1);
        checks++;
        if (level !== 4'd1) begin
            errors++;
            $display("FAIL level_after_two: got %0d expected 1", level);
        end
        step(2);
        lane_caught = 4'b0000;
        checks++;
        if (level !== 4'd2 || score !== 16'd4) begin
            errors++;
            $display("FAIL level_after_four: got level=%0d score=%0d expected level=2 score=4", level, score);
        end
        wait_launch(40, at1, val);
        checks++;
        if (at1 - t0 !== 21 || val !== 4'b0010) begin
            errors++;
            $display("FAIL level_first_launch: got %0d cycles lane %b expected 21 cycles lane 0010", at1 - t0, val);
        end
        lane_caught = 4'b0001;
        step(4);
        lane_caught = 4'b0000;
        checks++;
        if (level !== 4'd4 || score !== 16'd8) begin
            errors++;
            $display("FAIL level_after_eight: got level=%0d score=%0d expected level=4 score=8", level, score);
        end
        wait_launch(40, at2, val);
        checks++;
        if (at2 - at1 !== 13 || val !== 4'b1000) begin
            errors++;
            $display("FAIL level2_interval: got %0d cycles lane %b expected 13 cycles lane 1000", at2 - at1, val);
        end
        wait_launch(40, at3, val);
        checks++;
        if (at3 - at2 !== 9 || val !== 4'b1000) begin
            errors++;
            $display("FAIL level4_min_interval: got %0d cycles lane %b expected 9 cycles lane 1000", at3 - at2, val);
        end
    endtask

    task automatic test_game_over();
        int t0, bad;
        do_reset();
        start_game(t0);
        lane_caught = 4'b1000;
        lane_missed = 4'b0001;
        step(1);
        checks++;
        if (retire !== 4'b1001 || score !== 16'd1 || misses !== 2'd1) begin
            errors++;
            $display("FAIL go_first_miss: got retire=%b score=%0d misses=%0d expected 1001 1 1", retire, score, misses);
        end
        lane_caught = 4'b0100;
        lane_missed = 4'b0010;
        step(1);
        checks++;
        if (misses !== 2'd2 || game_over !== 1'b0 || level !== 4'd1) begin
            errors++;
            $display("FAIL go_second_miss: got misses=%0d game_over=%b level=%0d expected 2 0 1", misses, game_over, level);
        end
        lane_caught = 4'b0000;
        lane_missed = 4'b1100;
        step(1);
        lane_missed = 4'b0000;
        checks++;
        if (game_over !== 1'b1 || running !== 1'b0 || retire !== 4'b1111 || misses !== 2'd3) begin
            errors++;
            $display("FAIL go_enter: got game_over=%b running=%b retire=%b misses=%0d expected 1 0 1111 3",
                     game_over, running, retire, misses);
        end
        step(1);
        checks++;
        if (retire !== 4'b0000) begin
            errors++;
            $display("FAIL go_retire_pulse: got %b expected 0000", retire);
        end
        lane_caught = 4'b0001;
        lane_missed = 4'b0010;
        step(1);
        lane_caught = 4'b0000;
        lane_missed = 4'b0000;
        checks++;
        if (retire !== 4'b0000 || score !== 16'd2 || misses !== 2'd3) begin
            errors++;
            $display("FAIL go_events_ignored: got retire=%b score=%0d misses=%0d expected 0000 2 3", retire, score, misses);
        end
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            step(1);
            if (launch !== 4'b0000) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL go_no_launch: got %0d launch cycles expected 0", bad);
        end
        start_game(t0);
        checks++;
        if (running !== 1'b1 || game_over !== 1'b0 || score !== 16'd0 || level !== 4'd0 || misses !== 2'd0) begin
            errors++;
            $display("FAIL go_restart: got running=%b game_over=%b score=%0d level=%0d misses=%0d expected 1 0 0 0 0",
                     running, game_over, score, level, misses);
        end
    endtask

    task automatic test_pause();
        int t0, at, bad;
        logic [3:0] val;
        do_reset();
        start_game(t0);
        step(5);
        pause = 1'b1;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            lane_caught = (i == 50) ? 4'b0010 : 4'b0000;
            step(1);
            if (launch !== 4'b0000 || retire !== 4'b0000) bad++;
        end
        lane_caught = 4'b0000;
        pause = 1'b0;
        checks++;
        if (bad !== 0 || score !== 16'd0) begin
            errors++;
            $display("FAIL pause_frozen: got %0d active cycles score=%0d expected 0 0", bad, score);
        end
        wait_launch(60, at, val);
        checks++;
        if (at - t0 !== 121 || val !== 4'b0010) begin
            errors++;
            $display("FAIL pause_delay: got %0d cycles lane %b expected 121 cycles lane 0010", at - t0, val);
        end
    endtask

    task automatic test_reset_mid();
        int t0, at;
        logic [3:0] val;
        do_reset();
        start_game(t0);
        lane_caught = 4'b0001;
        lane_missed = 4'b0010;
        step(1);
        lane_caught = 4'b0000;
        lane_missed = 4'b0000;
        checks++;
        if (score !== 16'd1 || misses !== 2'd1) begin
            errors++;
            $display("FAIL mid_pre_reset: got score=%0d misses=%0d expected 1 1", score, misses);
        end
        step(3);
        lane_caught = 4'b0100;
        reset = 1'b0;
        step(1);
        lane_caught = 4'b0000;
        checks++;
        if ({launch, retire, score, level, misses, running, game_over} !== 34'd0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got launch=%b retire=%b score=%0d level=%0d misses=%0d running=%b game_over=%b, expected all zero",
                     launch, retire, score, level, misses, running, game_over);
        end
        reset = 1'b1;
        start_game(t0);
        wait_launch(40, at, val);
        checks++;
        if (at - t0 !== 21 || val !== 4'b0010) begin
            errors++;
            $display("FAIL mid_reset_relaunch: got %0d cycles lane %b expected 21 cycles lane 0010", at - t0, val);
        end
    endtask

    initial begin
        test_reset();
        test_first_launch();
        test_all_busy();
        test_events();
        test_level();
        test_game_over();
        test_pause();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
